// File: rtl/prism_sp_puzzle_hw_gem_rx_ring_release_pkg.sv
// Shared types and helpers for the GEM RX descriptor release stage (package prism_sp_config).
// Cookie layout, FSM states and descriptor word builders.
package prism_sp_config;

  localparam int unsigned RX_INDEX_WIDTH       = 10;
  localparam int unsigned RX_COOKIE_WIDTH      = 64;
  localparam int unsigned GEM_RX_DESC_OWN_BIT  = 0;
  localparam int unsigned GEM_RX_DESC_WRAP_BIT = 1;
  localparam logic [1:0]  AXI_RESP_OKAY        = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR       = 2'b01;

  typedef struct packed {
    logic [RX_COOKIE_WIDTH-RX_INDEX_WIDTH-48:0] pad;
    logic [RX_INDEX_WIDTH-1:0]                  index;
    logic [31:0]                                word0;
    logic [12:0]                                length;
    logic                                       sof;
    logic                                       eof;
  } rx_cookie_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W1   = 3'd1,
    ST_B1   = 3'd2,
    ST_W0   = 3'd3,
    ST_B0   = 3'd4,
    ST_PUSH = 3'd5
  } rx_release_state_t;

  function automatic logic [31:0] desc_word1(input rx_cookie_t c);
    return {16'h0000, c.eof, c.sof, 1'b0, c.length};
  endfunction

  // Ownership handed back to software; wrap bit and the rest pass through untouched.
  function automatic logic [31:0] desc_word0(input rx_cookie_t c);
    logic [31:0] w;
    w = c.word0;
    w[GEM_RX_DESC_OWN_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/prism_sp_puzzle_hw_gem_rx_ring_release_axi.sv
// Single-beat AXI write engine (prism_sp_axi_single_write): one AW, one W, one B per start pulse.
// AW and W complete independently; bready rises once both have been accepted.
import prism_sp_config::*;

module prism_sp_axi_single_write #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  output logic                  addr_data_done,
  output logic                  done,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = 4'hF;
  assign wlast   = 1'b1;

  // High in the cycle the last outstanding AW/W handshake completes.
  assign addr_data_done = (awvalid || wvalid) && !(awvalid && !awready) && !(wvalid && !wready);
  assign done = bvalid && bready;
  assign resp = bresp;

  always_ff @(posedge clock) begin
    if (reset) begin
      awaddr  <= '0;
      wdata   <= 32'h0000_0000;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      if (start) begin
        awaddr  <= addr;
        wdata   <= data;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else begin
        if (awvalid && awready) awvalid <= 1'b0;
        if (wvalid && wready)   wvalid  <= 1'b0;
      end
      if (addr_data_done)  bready <= 1'b1;
      else if (done)       bready <= 1'b0;
    end
  end

endmodule

// File: rtl/prism_sp_puzzle_hw_gem_rx_ring_release.sv
// GEM RX descriptor release: writes status word 1, then ownership word 0, then forwards the cookie.
// Optional sticky bresp checking under `PRISM_SP_RX_RELEASE_BRESP_CHECK_EN.
import prism_sp_config::*;

module prism_sp_puzzle_hw_gem_rx_ring_release #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 10,
  parameter int COOKIE_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   dma_desc_base,
  output logic                    cookie_rd_en,
  input  logic                    cookie_empty,
  input  logic [COOKIE_WIDTH-1:0] cookie_data,
  output logic                    out_wr_en,
  input  logic                    out_full,
  output logic [COOKIE_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [31:0]             released_count,
  output logic                    bresp_error
);

  rx_release_state_t     state_r, state_next_s;
  rx_cookie_t            cookie_src_s;
  logic [ADDR_WIDTH-1:0] desc_addr_s, wr_addr_s;
  logic [31:0]           wr_data_s;
  logic                  wr_start_s, wr_ad_done_s, wr_done_s;
  logic [1:0]            wr_resp_s;
  logic                  unused_pad_s;

  // Word 1 is issued straight from the FIFO head at pop time; word 0 from the held copy.
  assign cookie_src_s = (state_r == ST_IDLE) ? rx_cookie_t'(cookie_data) : rx_cookie_t'(out_data);
  assign desc_addr_s  = dma_desc_base + ADDR_WIDTH'({cookie_src_s.index[INDEX_WIDTH-1:0], 3'b000});
  assign wr_addr_s    = (state_r == ST_IDLE) ? desc_addr_s + {{(ADDR_WIDTH-3){1'b0}}, 3'b100} : desc_addr_s;
  assign wr_data_s    = (state_r == ST_IDLE) ? desc_word1(cookie_src_s) : desc_word0(cookie_src_s);
  assign unused_pad_s = ^cookie_src_s.pad;

  prism_sp_axi_single_write #(.ADDR_WIDTH(ADDR_WIDTH)) u_axi_wr (
    .clock          (clock),
    .reset          (reset),
    .start          (wr_start_s),
    .addr           (wr_addr_s),
    .data           (wr_data_s),
    .addr_data_done (wr_ad_done_s),
    .done           (wr_done_s),
    .resp           (wr_resp_s),
    .awaddr         (awaddr),
    .awvalid        (awvalid),
    .awready        (awready),
    .awlen          (awlen),
    .awsize         (awsize),
    .awburst        (awburst),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wlast          (wlast),
    .wvalid         (wvalid),
    .wready         (wready),
    .bresp          (bresp),
    .bvalid         (bvalid),
    .bready         (bready)
  );

  // Next-state and handshake strobes.
  always_comb begin
    state_next_s = state_r;
    cookie_rd_en = 1'b0;
    out_wr_en    = 1'b0;
    wr_start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && !cookie_empty) begin
          cookie_rd_en = 1'b1;
          wr_start_s   = 1'b1;
          state_next_s = ST_W1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_W1:   state_next_s = wr_ad_done_s ? ST_B1 : ST_W1;
      ST_B1: begin
        if (wr_done_s) begin
          wr_start_s   = 1'b1;
          state_next_s = ST_W0;
        end else begin
          state_next_s = ST_B1;
        end
      end
      ST_W0:   state_next_s = wr_ad_done_s ? ST_B0 : ST_W0;
      ST_B0:   state_next_s = wr_done_s ? ST_PUSH : ST_B0;
      ST_PUSH: begin
        if (!out_full) begin
          out_wr_en    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PUSH;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, held cookie and release counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      out_data       <= '0;
      released_count <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (cookie_rd_en) out_data <= cookie_data;
      if (out_wr_en)    released_count <= released_count + 32'd1;
    end
  end

`ifdef PRISM_SP_RX_RELEASE_BRESP_CHECK_EN
  // Sticky error on any non-OKAY write response; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset)                                       bresp_error <= 1'b0;
    else if (wr_done_s && wr_resp_s != AXI_RESP_OKAY) bresp_error <= 1'b1;
    else                                             bresp_error <= bresp_error;
  end
`else
  logic unused_resp_s;
  assign unused_resp_s = ^wr_resp_s;
  assign bresp_error   = 1'b0;
`endif

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_rx_ring_release.sv
// Directed bench for the RX ring release stage with a configurable single-beat AXI slave.
import prism_sp_config::*;

module tb_prism_sp_puzzle_hw_gem_rx_ring_release;

`ifdef PRISM_SP_RX_RELEASE_BRESP_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [31:0] dma_desc_base = 32'h1000_0000;
  logic cookie_rd_en, cookie_empty = 1'b1, out_wr_en, out_full = 1'b0;
  logic [63:0] cookie_data = 64'h0, out_data;
  logic [31:0] awaddr, wdata, released_count;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready, bresp_error;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp = 2'b00;
  logic [3:0] wstrb;

  int checks = 0, errors = 0, cyc = 0, exp_count = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 1;
  logic [1:0] bresp_w1 = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, cur_awhi = 0, cur_whi = 0, unstable = 0, viol = 0;
  bit aw_got = 0, w_got = 0, busy = 0;
  logic [31:0] log_addr[$], log_data[$];
  int log_aw_cyc[$], log_b_cyc[$];

  prism_sp_puzzle_hw_gem_rx_ring_release dut (
    .clock(clock), .reset(reset), .enable(enable), .dma_desc_base(dma_desc_base),
    .cookie_rd_en(cookie_rd_en), .cookie_empty(cookie_empty), .cookie_data(cookie_data),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_data(out_data),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .released_count(released_count), .bresp_error(bresp_error));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // AXI slave: readies after aw_wait/w_wait cycles, B after b_wait cycles once AW and W are in.
  always @(posedge clock) begin
    #2;
    if (reset) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_got = 0; w_got = 0; busy = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (bvalid) begin
        bvalid = 1'b0; bresp = 2'b00; aw_got = 0; w_got = 0; busy = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (awready) begin awready = 1'b0; aw_got = 1; end
      if (wready)  begin wready = 1'b0;  w_got = 1;  end
      if ((awvalid || wvalid) && !busy) begin
        busy = 1; cur_awhi = 0; cur_whi = 0;
        log_addr.push_back(awaddr); log_data.push_back(wdata); log_aw_cyc.push_back(cyc);
      end
      if (awvalid && awaddr !== log_addr[log_addr.size()-1]) unstable++;
      if (wvalid && wdata !== log_data[log_data.size()-1]) unstable++;
      if (bready && (awvalid || wvalid)) viol++;
      if (awvalid && !aw_got) begin
        cur_awhi++;
        if (aw_cnt >= aw_wait) awready = 1'b1; else aw_cnt++;
      end
      if (wvalid && !w_got) begin
        cur_whi++;
        if (w_cnt >= w_wait) wready = 1'b1; else w_cnt++;
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= b_wait) begin
          bvalid = 1'b1;
          bresp  = log_addr[log_addr.size()-1][2] ? bresp_w1 : 2'b00;
          log_b_cyc.push_back(cyc);
        end else b_cnt++;
      end
    end
  end

  function automatic logic [63:0] mk(input logic [9:0] idx, input logic [31:0] w0,
                                     input logic [12:0] len, input logic sof, input logic eof);
    rx_cookie_t c;
    c = '0; c.index = idx; c.word0 = w0; c.length = len; c.sof = sof; c.eof = eof;
    return c;
  endfunction

  task automatic pop_cookie(input logic [63:0] c, output int pc);
    bit ok = 0;
    pc = -1;
    @(posedge clock); #1 cookie_data = c; cookie_empty = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cookie_rd_en) begin pc = cyc; ok = 1; break; end
    end
    @(posedge clock); #1 cookie_empty = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL pop_timeout got no cookie_rd_en exp pop within 40 cycles"); end
  endtask

  task automatic wait_push(output int wc, output logic [63:0] od);
    bit ok = 0;
    wc = -1; od = 64'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (out_wr_en) begin wc = cyc; od = out_data; ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL push_timeout got no out_wr_en exp push within 200 cycles"); end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_aw_cyc.delete(); log_b_cyc.delete();
    unstable = 0; viol = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++; if ({cookie_rd_en, out_wr_en, awvalid, wvalid, bready, bresp_error} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {cookie_rd_en, out_wr_en, awvalid, wvalid, bready, bresp_error}); end
    checks++; if ({awaddr, wdata, released_count} !== 96'h0) begin
      errors++; $display("FAIL reset_regs got %h %h %h exp 0", awaddr, wdata, released_count); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if ({awlen, awsize, awburst, wstrb, wlast} !== {8'd0, 3'b010, 2'b01, 4'hF, 1'b1}) begin
      errors++; $display("FAIL axi_consts got %h %b %b %h %b", awlen, awsize, awburst, wstrb, wlast); end
  endtask

  task automatic test_basic();
    int pc, wc; logic [63:0] c, od;
    c = mk(10'd5, 32'h2000_0002, 13'd1514, 1'b1, 1'b1);
    clear_logs(); enable = 1'b1;
    pop_cookie(c, pc); wait_push(wc, od); exp_count++;
    checks++; if (wc - pc !== 7) begin errors++; $display("FAIL basic_latency got %0d exp 7", wc - pc); end
    checks++; if (od !== c) begin errors++; $display("FAIL basic_out_data got %h exp %h", od, c); end
    checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL basic_nwrites got %0d exp 2", log_addr.size()); end
    checks++; if (log_addr[0] !== 32'h1000_002C || log_data[0] !== 32'h0000_C5EA) begin
      errors++; $display("FAIL basic_word1 got %h=%h exp 1000002c=0000c5ea", log_addr[0], log_data[0]); end
    checks++; if (log_addr[1] !== 32'h1000_0028 || log_data[1] !== 32'h2000_0003) begin
      errors++; $display("FAIL basic_word0 got %h=%h exp 10000028=20000003", log_addr[1], log_data[1]); end
    @(negedge clock);
    checks++; if (released_count !== exp_count) begin errors++; $display("FAIL basic_count got %0d exp %0d", released_count, exp_count); end
  endtask

  task automatic test_delayed_b();
    int pc, wc; logic [63:0] c, od;
    c = mk(10'd2, 32'h0000_0000, 13'd60, 1'b1, 1'b0);
    clear_logs(); b_wait = 20; dma_desc_base = 32'h8000_0000;
    pop_cookie(c, pc); wait_push(wc, od); exp_count++;
    checks++; if (log_aw_cyc[1] !== log_b_cyc[0] + 1) begin
      errors++; $display("FAIL delayb_aw0_start got %0d exp %0d", log_aw_cyc[1], log_b_cyc[0] + 1); end
    checks++; if (wc - pc !== 45) begin errors++; $display("FAIL delayb_latency got %0d exp 45", wc - pc); end
    checks++; if (log_addr[0] !== 32'h8000_0014 || log_data[0] !== 32'h0000_403C || log_addr[1] !== 32'h8000_0010 || log_data[1] !== 32'h0000_0001) begin
      errors++; $display("FAIL delayb_words got %h=%h %h=%h", log_addr[0], log_data[0], log_addr[1], log_data[1]); end
    b_wait = 1; dma_desc_base = 32'h1000_0000;
  endtask

  task automatic test_aw_stall();
    int pc, wc; logic [63:0] c, od;
    c = mk(10'd3, 32'h5555_0000, 13'd64, 1'b0, 1'b1);
    clear_logs(); aw_wait = 5;
    pop_cookie(c, pc); wait_push(wc, od); exp_count++;
    checks++; if (cur_whi !== 1) begin errors++; $display("FAIL stall_wvalid_cycles got %0d exp 1", cur_whi); end
    checks++; if (cur_awhi !== 6) begin errors++; $display("FAIL stall_awvalid_cycles got %0d exp 6", cur_awhi); end
    checks++; if (unstable !== 0 || viol !== 0) begin errors++; $display("FAIL stall_stability got unstable=%0d bready_early=%0d exp 0 0", unstable, viol); end
    checks++; if (wc - pc !== 17) begin errors++; $display("FAIL stall_latency got %0d exp 17", wc - pc); end
    @(negedge clock);
    checks++; if (released_count !== exp_count) begin errors++; $display("FAIL stall_count got %0d exp %0d", released_count, exp_count); end
    aw_wait = 0;
  endtask

  task automatic test_back_to_back();
    int pc, wc, push1, pop2, early; bit pushed; logic [63:0] c2, c3, od, od1;
    c2 = mk(10'd0, 32'hABCD_0000, 13'd0, 1'b0, 1'b1);
    c3 = mk(10'd1023, 32'h0000_0002, 13'h1FFF, 1'b1, 1'b0);
    clear_logs();
    pop_cookie(c2, pc);
    cookie_data = c3; cookie_empty = 1'b0; out_full = 1'b1;
    pushed = 0; early = 0; pop2 = -1; push1 = -1; od1 = 64'h0;
    for (int i = 0; i < 60 && pop2 < 0; i++) begin
      @(posedge clock); #1;
      if (cyc == pc + 17) out_full = 1'b0;
      @(negedge clock);
      if (cookie_rd_en && !pushed) early++;
      if (cookie_rd_en && pushed) pop2 = cyc;
      if (out_wr_en) begin push1 = cyc; od1 = out_data; pushed = 1; end
    end
    @(posedge clock); #1 cookie_empty = 1'b1; out_full = 1'b0;
    exp_count++;
    checks++; if (push1 !== pc + 17) begin errors++; $display("FAIL full_push_cycle got %0d exp %0d", push1, pc + 17); end
    checks++; if (early !== 0) begin errors++; $display("FAIL full_no_pop got %0d exp 0", early); end
    checks++; if (pop2 !== push1 + 1) begin errors++; $display("FAIL b2b_next_pop got %0d exp %0d", pop2, push1 + 1); end
    checks++; if (od1 !== c2) begin errors++; $display("FAIL full_out_data got %h exp %h", od1, c2); end
    wait_push(wc, od); exp_count++;
    checks++; if (od !== c3 || wc - pop2 !== 7) begin errors++; $display("FAIL b2b_second got %h lat %0d exp %h lat 7", od, wc - pop2, c3); end
    checks++; if (log_addr[0] !== 32'h1000_0004 || log_data[0] !== 32'h0000_8000 || log_addr[1] !== 32'h1000_0000 || log_data[1] !== 32'hABCD_0001) begin
      errors++; $display("FAIL b2b_words_a got %h=%h %h=%h", log_addr[0], log_data[0], log_addr[1], log_data[1]); end
    checks++; if (log_addr[2] !== 32'h1000_1FFC || log_data[2] !== 32'h0000_5FFF || log_addr[3] !== 32'h1000_1FF8 || log_data[3] !== 32'h0000_0003) begin
      errors++; $display("FAIL b2b_words_b got %h=%h %h=%h", log_addr[2], log_data[2], log_addr[3], log_data[3]); end
    @(negedge clock);
    checks++; if (released_count !== exp_count) begin errors++; $display("FAIL b2b_count got %0d exp %0d", released_count, exp_count); end
  endtask

  task automatic test_enable();
    int pc, wc, extra; logic [63:0] c4, od;
    c4 = mk(10'd7, 32'h1234_5679, 13'd100, 1'b0, 1'b0);
    clear_logs();
    pop_cookie(c4, pc);
    enable = 1'b0; cookie_empty = 1'b0; cookie_data = mk(10'd8, 32'h0, 13'd1, 1'b1, 1'b1);
    wait_push(wc, od); exp_count++;
    checks++; if (od !== c4 || wc - pc !== 7) begin errors++; $display("FAIL enable_finish got %h lat %0d exp %h lat 7", od, wc - pc, c4); end
    extra = 0;
    repeat (10) begin @(negedge clock); if (cookie_rd_en) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL enable_no_pop got %0d exp 0", extra); end
    checks++; if (released_count !== exp_count) begin errors++; $display("FAIL enable_count got %0d exp %0d", released_count, exp_count); end
    cookie_empty = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int pc, wc; logic [63:0] c, od;
    c = mk(10'd9, 32'h0000_0000, 13'd200, 1'b1, 1'b1);
    clear_logs(); b_wait = 20;
    pop_cookie(c, pc);
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL midreset_in_b1 got bready=%b exp 1", bready); end
    @(posedge clock); #1 reset = 1'b1; b_wait = 1;
    @(posedge clock); #1 reset = 1'b0; cookie_data = c; cookie_empty = 1'b0;
    exp_count = 0;
    @(negedge clock);
    checks++; if ({out_wr_en, awvalid, wvalid, bready, bresp_error} !== 5'b0 || {awaddr, wdata, released_count} !== 96'h0 || out_data !== 64'h0) begin
      errors++; $display("FAIL midreset_values got %b %h %h %0d %h exp zeros", {out_wr_en, awvalid, wvalid, bready, bresp_error}, awaddr, wdata, released_count, out_data); end
    checks++; if (cookie_rd_en !== 1'b1) begin errors++; $display("FAIL midreset_idle got rd_en=%b exp 1", cookie_rd_en); end
    @(posedge clock); #1 cookie_empty = 1'b1;
    wait_push(wc, od); exp_count++;
    checks++; if (od !== c) begin errors++; $display("FAIL midreset_recover got %h exp %h", od, c); end
  endtask

  task automatic test_bresp();
    int pc, wc; logic [63:0] c, od;
    c = mk(10'd4, 32'h0000_0000, 13'd42, 1'b1, 1'b1);
    clear_logs(); bresp_w1 = 2'b10;
    pop_cookie(c, pc); wait_push(wc, od); exp_count++;
    bresp_w1 = 2'b00;
    @(negedge clock);
    checks++; if (bresp_error !== CHK_EN) begin errors++; $display("FAIL bresp_set got %b exp %b", bresp_error, CHK_EN); end
    checks++; if (released_count !== exp_count || od !== c) begin errors++; $display("FAIL bresp_forward got %0d %h exp %0d %h", released_count, od, exp_count, c); end
    pop_cookie(c, pc); wait_push(wc, od); exp_count++;
    @(negedge clock);
    checks++; if (bresp_error !== CHK_EN) begin errors++; $display("FAIL bresp_sticky got %b exp %b", bresp_error, CHK_EN); end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (bresp_error !== 1'b0 || released_count !== 32'd0) begin
      errors++; $display("FAIL bresp_clear got %b %0d exp 0 0", bresp_error, released_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_b();
    test_aw_stall();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_bresp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prism_sp_puzzle_hw_gem_rx_ring_release.md
# prism_sp_puzzle_hw_gem_rx_ring_release

RX-side counterpart of the TX descriptor acquire stage: it takes completed RX cookies (descriptor index, original word 0, frame length, SOF/EOF) from the RX DMA-write stage and writes the GEM RX descriptor back to memory over an AXI master. The status word is written first; the word carrying the ownership bit is written only after the status write is acknowledged, so software never sees a used descriptor with stale status. Each released cookie is then forwarded unchanged to the RX IRQ stage's FIFO.

## Interface
- `ADDR_WIDTH`, 32: system address width.
- `INDEX_WIDTH`, 10: descriptor index width; ring holds up to 2^INDEX_WIDTH descriptors.
- `COOKIE_WIDTH`, 64: cookie width; fields listed in Structure.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits popping new cookies.
- `dma_desc_base` in ADDR_WIDTH: ring base; 8-byte aligned.
- `cookie_rd_en` out 1: pops the input FIFO (first-word-fall-through).
- `cookie_empty` in 1: input FIFO empty.
- `cookie_data` in COOKIE_WIDTH: head entry, valid while !empty.
- `out_wr_en` out 1: pushes the output FIFO.
- `out_full` in 1: output FIFO full.
- `out_data` out COOKIE_WIDTH: forwarded cookie.
- `awaddr` out ADDR_WIDTH; `awvalid` out 1; `awready` in 1; `awlen` out 8 (=0); `awsize` out 3 (=3'b010); `awburst` out 2 (=INCR).
- `wdata` out 32; `wstrb` out 4 (=4'hF); `wlast` out 1 (=1); `wvalid` out 1; `wready` in 1.
- `bresp` in 2; `bvalid` in 1; `bready` out 1.
- `released_count` out 32: descriptors released; wraps modulo 2^32.
- `bresp_error` out 1: sticky error flag (see Configuration).

## Operation
- Descriptor address: `dma_desc_base + {index, 3'b000}`; word 0 at +0, word 1 at +4.
- Word 1 written as: [12:0] length, [14] SOF, [15] EOF, all other bits 0.
- Word 0 written as: original word 0 with bit 0 (ownership) forced to 1; wrap bit 1 preserved.
- FSM states:
  - IDLE: when `enable && !cookie_empty`, pulse `cookie_rd_en`, latch cookie → W1.
  - W1: drive AW/W for word 1. AW and W complete independently; each valid drops on its own handshake → B1 when both are done.
  - B1: `bready`=1; on `bvalid` → W0.
  - W0: as W1, for word 0 → B0.
  - B0: `bready`=1; on `bvalid` → PUSH.
  - PUSH: `out_wr_en`=1 when `!out_full`, increment `released_count` in the same cycle → IDLE. Stalls while full.
- `enable` deasserted mid-descriptor: the current descriptor completes through PUSH; no new pop occurs.
- AXI: `awvalid`/`wvalid` never drop before their handshake. Address and data stay stable while valid. At most one transaction is outstanding.
- Ring wrap is carried only by the cookie's wrap bit; no index arithmetic happens here.

## Timing
- Reset values: all valid/enable outputs 0, `bready` 0, `awaddr`/`wdata`/`out_data` 0, `released_count` 0, `bresp_error` 0, state IDLE.
- Reset mid-operation: everything returns to IDLE at once. Any outstanding AXI transaction is abandoned; the interconnect is reset in the same domain.
- Latency with zero-wait AXI (same-cycle ready, B one cycle after the W handshake): pop at cycle 0, W1 at 1, B1 at 2–3, W0 at 4, B0 at 5–6, push at 7. Total 8 cycles per descriptor.
- Back-to-back cookies: the next pop happens in the cycle after PUSH (IDLE visited once).
- `out_data` is registered and held from the pop until the push.

## Configuration
- `PRISM_SP_RX_RELEASE_BRESP_CHECK_EN` defined:
  - A `bresp` ≠ OKAY on either write sets the sticky `bresp_error`, cleared only by `reset`.
  - The descriptor is still forwarded and counted.
- Undefined: `bresp` is ignored and `bresp_error` is tied to 0.

## Structure
- Package `prism_sp_config`: `rx_cookie_t` packed struct (`index` INDEX_WIDTH, `word0` 32, `length` 13, `sof` 1, `eof` 1, padding), plus `GEM_RX_DESC_OWN_BIT`=0 and `GEM_RX_DESC_WRAP_BIT`=1.
- One sub-module: `prism_sp_axi_single_write`, which handles one beat of AW/W/B (start, addr, data → done, resp). It is instantiated once and reused for W1 and W0.

## Test plan
- base=0x1000_0000, cookie {index=5, word0=0x2000_0002, length=1514, sof=1, eof=1} → write 0x1000_002C=0x0000_C5EA, then 0x1000_0028=0x2000_0003; one push; count=1.
- B of word 1 delayed 20 cycles → no AW for word 0 until 1 cycle after that `bvalid`.
- `awready` low 5 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` held stable; B1 entered only after AW accepted.
- `out_full` held 10 cycles in PUSH → no pop, `out_wr_en` on cycle 11; next cookie popped the cycle after.
- Macro defined, `bresp`=SLVERR on word 1 → `bresp_error`=1 and persists; descriptor still pushed; reset clears it.
- `reset` asserted during B1 → IDLE next cycle, all outputs at reset values, `released_count`=0.
